// File: rtl/text_console_ctrl.sv
// text_console_ctrl: write-side controller for the character RAM.
// Interprets a byte stream (printable characters plus CR/LF/BS/FF), tracks
// the text cursor and owns the RAM write port, including the power-up /
// requested full-screen clear and the line clear that follows a newline or
// a wrap. The display side of the RAM is read-only.
module text_console_ctrl #(
    parameter int         COLS   = 40,
    parameter int         ROWS   = 30,
    parameter int         COL_W  = 6,
    parameter int         ROW_W  = 5,
    parameter int         ADDR_W = ROW_W + COL_W,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              px_clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clr,
    output logic              write_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [7:0]       CH_BS    = 8'h08;
    localparam logic [7:0]       CH_LF    = 8'h0A;
    localparam logic [7:0]       CH_FF    = 8'h0C;
    localparam logic [7:0]       CH_CR    = 8'h0D;
    localparam logic [7:0]       CH_FIRST = 8'h20;
    localparam logic [7:0]       CH_LAST  = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_LINE   = 2'd1,
        ST_CLR_SCREEN = 2'd2
    } state_t;

    state_t           state_r;
    logic [COL_W-1:0] clr_col_r;   // sweep column for both clear kinds
    logic [ROW_W-1:0] clr_row_r;   // sweep row (fixed during a line clear)

    logic             accept_s;
    logic             printable_s;
    logic [ROW_W-1:0] next_row_s;

    // Row increment that wraps from the last visible row back to row 0.
    function automatic logic [ROW_W-1:0] wrap_inc_row(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] res;
        if (row == LAST_ROW) begin
            res = {ROW_W{1'b0}};
        end else begin
            res = row + ROW_W'(1'b1);
        end
        return res;
    endfunction

    assign accept_s    = in_valid && in_ready;
    assign printable_s = (in_data >= CH_FIRST) && (in_data <= CH_LAST);
    assign next_row_s  = wrap_inc_row(cursor_row);

    // Sequencer: byte interpretation, cursor tracking and the two clear sweeps.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_CLR_SCREEN;
            clr_col_r  <= {COL_W{1'b0}};
            clr_row_r  <= {ROW_W{1'b0}};
            cursor_col <= {COL_W{1'b0}};
            cursor_row <= {ROW_W{1'b0}};
            write_en   <= 1'b0;
            waddr      <= {ADDR_W{1'b0}};
            wdata      <= 8'h00;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr || (accept_s && (in_data == CH_FF))) begin
                        // clr wins over any offered byte; FF behaves the same
                        state_r    <= ST_CLR_SCREEN;
                        clr_col_r  <= {COL_W{1'b0}};
                        clr_row_r  <= {ROW_W{1'b0}};
                        cursor_col <= {COL_W{1'b0}};
                        cursor_row <= {ROW_W{1'b0}};
                        write_en   <= 1'b0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end else if (accept_s && printable_s) begin
                        write_en <= 1'b1;
                        waddr    <= {cursor_row, cursor_col};
                        wdata    <= in_data;
                        if (cursor_col == LAST_COL) begin
                            // wrap: the new row is cleared starting next edge
                            cursor_col <= {COL_W{1'b0}};
                            cursor_row <= next_row_s;
                            clr_row_r  <= next_row_s;
                            clr_col_r  <= {COL_W{1'b0}};
                            state_r    <= ST_CLR_LINE;
                            in_ready   <= 1'b0;
                            busy       <= 1'b1;
                        end else begin
                            cursor_col <= cursor_col + COL_W'(1'b1);
                        end
                    end else if (accept_s && (in_data == CH_LF)) begin
                        // the first blank of the line clear goes out right away
                        write_en   <= 1'b1;
                        waddr      <= {next_row_s, {COL_W{1'b0}}};
                        wdata      <= BLANK;
                        cursor_row <= next_row_s;
                        clr_row_r  <= next_row_s;
                        clr_col_r  <= COL_W'(1'b1);
                        state_r    <= ST_CLR_LINE;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end else if (accept_s && (in_data == CH_CR)) begin
                        write_en   <= 1'b0;
                        cursor_col <= {COL_W{1'b0}};
                    end else if (accept_s && (in_data == CH_BS) && (cursor_col != {COL_W{1'b0}})) begin
                        write_en   <= 1'b1;
                        waddr      <= {cursor_row, cursor_col - COL_W'(1'b1)};
                        wdata      <= BLANK;
                        cursor_col <= cursor_col - COL_W'(1'b1);
                    end else begin
                        // no byte, BS at column 0, or an unused control code
                        write_en <= 1'b0;
                    end
                end

                ST_CLR_LINE: begin
                    if (clr) begin
                        // abort the line and sweep the whole screen instead
                        state_r    <= ST_CLR_SCREEN;
                        clr_col_r  <= {COL_W{1'b0}};
                        clr_row_r  <= {ROW_W{1'b0}};
                        cursor_col <= {COL_W{1'b0}};
                        cursor_row <= {ROW_W{1'b0}};
                        write_en   <= 1'b0;
                    end else begin
                        write_en <= 1'b1;
                        waddr    <= {clr_row_r, clr_col_r};
                        wdata    <= BLANK;
                        if (clr_col_r == LAST_COL) begin
                            clr_col_r <= {COL_W{1'b0}};
                            state_r   <= ST_IDLE;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            clr_col_r <= clr_col_r + COL_W'(1'b1);
                        end
                    end
                end

                ST_CLR_SCREEN: begin
                    // clr is deliberately ignored here: the sweep never restarts
                    write_en <= 1'b1;
                    waddr    <= {clr_row_r, clr_col_r};
                    wdata    <= BLANK;
                    if (clr_col_r == LAST_COL) begin
                        clr_col_r <= {COL_W{1'b0}};
                        if (clr_row_r == LAST_ROW) begin
                            clr_row_r <= {ROW_W{1'b0}};
                            state_r   <= ST_IDLE;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            clr_row_r <= clr_row_r + ROW_W'(1'b1);
                        end
                    end else begin
                        clr_col_r <= clr_col_r + COL_W'(1'b1);
                    end
                end

                default: begin
                    // unreachable encoding: recover through a full clear
                    state_r    <= ST_CLR_SCREEN;
                    clr_col_r  <= {COL_W{1'b0}};
                    clr_row_r  <= {ROW_W{1'b0}};
                    cursor_col <= {COL_W{1'b0}};
                    cursor_row <= {ROW_W{1'b0}};
                    write_en   <= 1'b0;
                    in_ready   <= 1'b0;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed-vector bench for text_console_ctrl.
module tb_text_console_ctrl;

    logic        px_clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        clr;
    logic        write_en;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Record of every visible write, sampled mid-cycle.
    logic [10:0] q_addr[$];
    logic [7:0]  q_data[$];
    logic        q_rdy[$];

    always #5 px_clk = ~px_clk;

    text_console_ctrl dut (
        .px_clk     (px_clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .clr        (clr),
        .write_en   (write_en),
        .waddr      (waddr),
        .wdata      (wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    // Write logger.
    always @(negedge px_clk) begin
        if (write_en === 1'b1) begin
            q_addr.push_back(waddr);
            q_data.push_back(wdata);
            q_rdy.push_back(in_ready);
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_rdy.delete();
    endtask

    task automatic drive(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge px_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge px_clk); #1;
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge px_clk); #1;
    endtask

    task automatic test_reset();
        bit ok;
        int bad;
        logic [10:0] e;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr = 1'b0;
        repeat (3) @(posedge px_clk); #1;
        checks++;
        if ({write_en, waddr, wdata} !== 20'h0)
            $display("FAIL reset_wr: got %0h expected 0", {write_en, waddr, wdata});
        checks++;
        if ({busy, in_ready, cursor_row, cursor_col} !== {1'b1, 1'b0, 11'h0}) begin
            errors++;
            $display("FAIL reset_state: got %0h expected %0h", {busy, in_ready, cursor_row, cursor_col}, {1'b1, 1'b0, 11'h0});
        end
        if ({write_en, waddr, wdata} !== 20'h0) errors++;
        // reset asserted in the middle of a screen clear
        rst_n = 1'b1;
        repeat (100) @(posedge px_clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({write_en, waddr, busy, in_ready} !== {1'b0, 11'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midclear_reset: got %0h expected %0h", {write_en, waddr, busy, in_ready}, {1'b0, 11'h0, 1'b1, 1'b0});
        end
        @(negedge px_clk); #1;
        clear_log();
        rst_n = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_timeout: in_ready never rose"); end
        checks++;
        if (q_addr.size() !== 1200) begin
            errors++;
            $display("FAIL init_count: got %0d writes expected 1200", q_addr.size());
        end
        checks++;
        if ({write_en, waddr} !== {1'b1, 11'h767}) begin
            errors++;
            $display("FAIL init_last: got %0h expected %0h with ready rise", {write_en, waddr}, {1'b1, 11'h767});
        end
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            e = 11'(((i / 40) * 64) + (i % 40));
            if (q_addr[i] !== e || q_data[i] !== 8'h20 || (i < 1199 && q_rdy[i] !== 1'b0)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL init_sweep: got %0d bad writes expected 0", bad); end
        checks++;
        if ({busy, in_ready, cursor_row, cursor_col} !== {1'b0, 1'b1, 11'h0}) begin
            errors++;
            $display("FAIL init_done: got %0h expected %0h", {busy, in_ready, cursor_row, cursor_col}, {1'b0, 1'b1, 11'h0});
        end
    endtask

    task automatic test_single_char();
        drive(8'h41);
        checks++;
        if ({write_en, waddr, wdata} !== {1'b1, 11'h000, 8'h41}) begin
            errors++;
            $display("FAIL char_write: got %0h expected %0h", {write_en, waddr, wdata}, {1'b1, 11'h000, 8'h41});
        end
        checks++;
        if ({cursor_row, cursor_col} !== {5'd0, 6'd1}) begin
            errors++;
            $display("FAIL char_cursor: got %0h expected %0h", {cursor_row, cursor_col}, {5'd0, 6'd1});
        end
        @(posedge px_clk); #1;
        checks++;
        if (write_en !== 1'b0) begin errors++; $display("FAIL char_one_cycle: got %0b expected 0", write_en); end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        drive(8'h0D);
        checks++;
        if ({write_en, cursor_col} !== {1'b0, 6'd0}) begin
            errors++;
            $display("FAIL cr: got %0h expected 0", {write_en, cursor_col});
        end
        clear_log();
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(i);
            @(posedge px_clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready, cursor_row, cursor_col} !== {1'b1, 1'b0, 5'd1, 6'd0}) begin
            errors++;
            $display("FAIL wrap_state: got %0h expected %0h", {busy, in_ready, cursor_row, cursor_col}, {1'b1, 1'b0, 5'd1, 6'd0});
        end
        wait_idle(ok);
        checks++;
        if (!ok || q_addr.size() !== 80) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes expected 80", q_addr.size());
        end
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (i < 40) begin
                if (q_addr[i] !== 11'(i) || q_data[i] !== 8'h30 + 8'(i)) bad++;
            end else begin
                if (q_addr[i] !== 11'(24 + i) || q_data[i] !== 8'h20 || (i < 79 && q_rdy[i] !== 1'b0)) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wrap_sweep: got %0d bad writes expected 0", bad); end
    endtask

    task automatic test_lf_wrap_row();
        bit ok;
        int bad;
        int nok;
        drive(8'h7A);
        nok = 0;
        for (int i = 0; i < 28; i++) begin
            drive(8'h0A);
            wait_idle(ok);
            if (!ok) nok++;
        end
        checks++;
        if (nok !== 0 || {cursor_row, cursor_col} !== {5'd29, 6'd1}) begin
            errors++;
            $display("FAIL lf_walk: got %0h expected %0h", {cursor_row, cursor_col}, {5'd29, 6'd1});
        end
        clear_log();
        drive(8'h0A);
        checks++;
        if ({write_en, waddr, wdata, cursor_row, cursor_col} !== {1'b1, 11'h000, 8'h20, 5'd0, 6'd1}) begin
            errors++;
            $display("FAIL lf_first: got %0h expected %0h", {write_en, waddr, wdata, cursor_row, cursor_col}, {1'b1, 11'h000, 8'h20, 5'd0, 6'd1});
        end
        wait_idle(ok);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] !== 11'(i) || q_data[i] !== 8'h20) bad++;
        checks++;
        if (!ok || q_addr.size() !== 40 || bad !== 0) begin
            errors++;
            $display("FAIL lf_sweep: got %0d writes %0d bad expected 40 0", q_addr.size(), bad);
        end
    endtask

    task automatic test_backspace();
        bit ok;
        drive(8'h0D);
        for (int i = 0; i < 3; i++) begin
            drive(8'h0A);
            wait_idle(ok);
        end
        clear_log();
        drive(8'h08);
        checks++;
        if ({write_en, cursor_row, cursor_col} !== {1'b0, 5'd3, 6'd0}) begin
            errors++;
            $display("FAIL bs_col0: got %0h expected %0h", {write_en, cursor_row, cursor_col}, {1'b0, 5'd3, 6'd0});
        end
        in_valid = 1'b1; in_data = 8'h78; @(posedge px_clk); #1;
        in_data = 8'h79; @(posedge px_clk); #1;
        in_data = 8'h08; @(posedge px_clk); #1;
        in_valid = 1'b0;
        @(negedge px_clk); #1;
        checks++;
        if (q_addr.size() !== 3) begin
            errors++;
            $display("FAIL bs_count: got %0d writes expected 3", q_addr.size());
        end else if ({q_addr[0], q_data[0], q_addr[1], q_data[1], q_addr[2], q_data[2]}
                     !== {11'h0C0, 8'h78, 11'h0C1, 8'h79, 11'h0C1, 8'h20}) begin
            errors++;
            $display("FAIL bs_writes: got %0h %0h %0h %0h %0h %0h expected 0c0 78 0c1 79 0c1 20",
                     q_addr[0], q_data[0], q_addr[1], q_data[1], q_addr[2], q_data[2]);
        end
        checks++;
        if ({cursor_row, cursor_col} !== {5'd3, 6'd1}) begin
            errors++;
            $display("FAIL bs_cursor: got %0h expected %0h", {cursor_row, cursor_col}, {5'd3, 6'd1});
        end
    endtask

    task automatic test_clr_abort();
        bit ok;
        int bad;
        logic [10:0] e;
        in_valid = 1'b1; in_data = 8'h0A;
        @(posedge px_clk); #1;
        in_data = 8'h4B;
        repeat (5) @(posedge px_clk); #1;
        checks++;
        if ({busy, cursor_row, cursor_col} !== {1'b1, 5'd4, 6'd1}) begin
            errors++;
            $display("FAIL abort_pre: got %0h expected %0h", {busy, cursor_row, cursor_col}, {1'b1, 5'd4, 6'd1});
        end
        clr = 1'b1;
        @(posedge px_clk); #1;
        clr = 1'b0;
        clear_log();
        checks++;
        if ({busy, in_ready, cursor_row, cursor_col} !== {1'b1, 1'b0, 11'h0}) begin
            errors++;
            $display("FAIL abort_entry: got %0h expected %0h", {busy, in_ready, cursor_row, cursor_col}, {1'b1, 1'b0, 11'h0});
        end
        wait_idle(ok);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            e = 11'(((i / 40) * 64) + (i % 40));
            if (q_addr[i] !== e || q_data[i] !== 8'h20 || (i < 1199 && q_rdy[i] !== 1'b0)) bad++;
        end
        checks++;
        if (!ok || q_addr.size() !== 1200 || bad !== 0) begin
            errors++;
            $display("FAIL abort_sweep: got %0d writes %0d bad expected 1200 0", q_addr.size(), bad);
        end
        checks++;
        if ({busy, cursor_row, cursor_col} !== {1'b0, 11'h0}) begin
            errors++;
            $display("FAIL abort_no_accept: got %0h expected 0", {busy, cursor_row, cursor_col});
        end
        @(posedge px_clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({write_en, waddr, wdata, cursor_row, cursor_col} !== {1'b1, 11'h000, 8'h4B, 5'd0, 6'd1}) begin
            errors++;
            $display("FAIL abort_pending: got %0h expected %0h", {write_en, waddr, wdata, cursor_row, cursor_col}, {1'b1, 11'h000, 8'h4B, 5'd0, 6'd1});
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_wrap();
        test_lf_wrap_row();
        test_backspace();
        test_clr_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
